// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode-0 peripheral on an 8-bit CPU register bus. An external master
// drives sclk/ss/mosi. The block synchronises those inputs into clk, shifts
// received bits into an RX register and returns the queued TX byte on miso.
//
// Ports
//   clk_i      system clock
//   reset_i    asynchronous, active-high reset
//   enable_i   bus access strobe, one clk per access
//   rnw_i      1 = read, 0 = write
//   addr_i     register select (0 data, 1 status/W1C, 2 irq mask)
//   din_i      write data
//   dout_o     registered read data (latency 1)
//   sclk_i     SPI clock from master, idles low
//   ss_i       slave select, active low
//   mosi_i     serial data from master
//   miso_o     serial data to master
//   miso_oe_o  high while selected
//   irq_o      level interrupt = |(status[3:0] & irq_mask)
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       rnw_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    input  logic       sclk_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic       irq_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser chains and previous-value flops for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ss_rise_s;
    logic ss_fall_s;

    // Architectural state
    state_t     state_q,    state_d;
    logic [7:0] shift_rx_q, shift_rx_d;
    logic [7:0] shift_tx_q, shift_tx_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic [7:0] tx_buf_q,   tx_buf_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [3:0] irq_mask_q, irq_mask_d;
    logic       rx_full_q,  rx_full_d;
    logic       tx_valid_q, tx_valid_d;
    logic       overrun_q,  overrun_d;
    logic       underrun_q, underrun_d;
    logic       miso_q,     miso_d;
    logic       miso_oe_q,  miso_oe_d;
    logic [7:0] dout_q,     dout_d;
    logic       irq_q,      irq_d;

    // Bus decode and event strobes
    logic       rd_rx_s;
    logic       wr_tx_s;
    logic       wr_st_s;
    logic       wr_msk_s;
    logic       load_tx_s;
    logic       rx_set_s;
    logic       ovr_set_s;
    logic       und_set_s;
    logic [7:0] loaded_s;
    logic [7:0] status_s;
    logic [7:0] rx_byte_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign ss_rise_s   = ss_s & ~ss_prev_q;
    assign ss_fall_s   = ~ss_s & ss_prev_q;

    assign status_s  = {3'b000, (state_q == ST_ACTIVE), underrun_q, overrun_q,
                        ~tx_valid_q, rx_full_q};
    assign loaded_s  = tx_valid_q ? tx_buf_q : FILL_BYTE;
    assign rx_byte_s = {shift_rx_q[6:0], mosi_s};

    assign dout_o    = dout_q;
    assign miso_o    = miso_q;
    assign miso_oe_o = miso_oe_q;
    assign irq_o     = irq_q;

    // Input synchronisers. The ss chain resets low so that an ss already low
    // at reset release produces no falling edge: a fresh frame needs ss to
    // rise and fall again.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Next-state logic: frame FSM, shifters, flags, bus registers, outputs
    always_comb begin
        state_d    = state_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        rx_data_d  = rx_data_q;
        tx_buf_d   = tx_buf_q;
        bit_cnt_d  = bit_cnt_q;
        irq_mask_d = irq_mask_q;
        rx_full_d  = rx_full_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        dout_d     = 8'h00;
        load_tx_s  = 1'b0;
        rx_set_s   = 1'b0;

        rd_rx_s  = enable_i & rnw_i  & (addr_i == 3'd0);
        wr_tx_s  = enable_i & ~rnw_i & (addr_i == 3'd0);
        wr_st_s  = enable_i & ~rnw_i & (addr_i == 3'd1);
        wr_msk_s = enable_i & ~rnw_i & (addr_i == 3'd2);

        case (state_q)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_d   = ST_ACTIVE;
                    load_tx_s = 1'b1;
                    bit_cnt_d = 3'd0;
                    miso_oe_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    // Deselect discards any partial byte; rx_full untouched.
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b1;
                    miso_oe_d = 1'b0;
                end else if (sclk_rise_s) begin
                    shift_rx_d = rx_byte_s;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d = rx_byte_s;
                        rx_set_s  = 1'b1;
                    end else begin
                        rx_set_s  = 1'b0;
                    end
                end else if (sclk_fall_s) begin
                    // bit_cnt has wrapped to 0 after the 8th rise: byte boundary.
                    if (bit_cnt_q == 3'd0) begin
                        load_tx_s = 1'b1;
                    end else begin
                        shift_tx_d = {shift_tx_q[6:0], 1'b0};
                        miso_d     = shift_tx_q[6];
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TX load samples pre-write tx_buf/tx_valid; a same-cycle a0 write
        // below re-queues and so survives for the next byte.
        und_set_s = load_tx_s & ~tx_valid_q;
        if (load_tx_s) begin
            shift_tx_d = loaded_s;
            tx_valid_d = 1'b0;
            miso_d     = loaded_s[7];
        end else begin
            tx_valid_d = tx_valid_q;
        end

        if (wr_tx_s) begin
            tx_buf_d   = din_i;
            tx_valid_d = 1'b1;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        // Overrun only if the old byte was not consumed in this same clk.
        ovr_set_s = rx_set_s & rx_full_q & ~rd_rx_s;

        // Clears first, sets last: a same-cycle set always wins.
        rx_full_d  = (rd_rx_s  ? 1'b0 : rx_full_q)  | rx_set_s;
        overrun_d  = ((wr_st_s & din_i[1]) ? 1'b0 : overrun_q)  | ovr_set_s;
        underrun_d = ((wr_st_s & din_i[2]) ? 1'b0 : underrun_q) | und_set_s;

        irq_mask_d = wr_msk_s ? din_i[3:0] : irq_mask_q;

        case (addr_i)
            3'd0:    dout_d = rx_data_q;
            3'd1:    dout_d = status_s;
            3'd2:    dout_d = {4'h0, irq_mask_q};
            default: dout_d = 8'h00;
        endcase

        // Built from next-state flags so irq tracks the flags without lag.
        irq_d = |({underrun_d, overrun_d, ~tx_valid_d, rx_full_d} & irq_mask_d);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shift_rx_q <= 8'h00;
            shift_tx_q <= 8'h00;
            rx_data_q  <= 8'h00;
            tx_buf_q   <= 8'h00;
            bit_cnt_q  <= 3'd0;
            irq_mask_q <= 4'h0;
            rx_full_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b1;
            miso_oe_q  <= 1'b0;
            dout_q     <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_rx_q <= shift_rx_d;
            shift_tx_q <= shift_tx_d;
            rx_data_q  <= rx_data_d;
            tx_buf_q   <= tx_buf_d;
            bit_cnt_q  <= bit_cnt_d;
            irq_mask_q <= irq_mask_d;
            rx_full_q  <= rx_full_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            dout_q     <= dout_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int PH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       rnw = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_miso_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] r;
    logic [7:0] v;

    spi_slave #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .rnw_i(rnw),
        .addr_i(addr), .din_i(din), .dout_o(dout), .sclk_i(sclk),
        .ss_i(ss), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b1; addr = a;
        @(negedge clk);
        enable = 1'b0;
        d = dout;
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    task automatic ss_high();
        @(negedge clk);
        ss = 1'b1;
        repeat (PH) @(negedge clk);
    endtask

    // Mode-0 master: mosi set while sclk low, miso sampled at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            repeat (PH) @(negedge clk);
            rx[7-i] = miso;
            sclk = 1'b1;
            repeat (PH) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (PH) @(negedge clk);
    endtask

    task automatic pop_miso(input string tag, input logic [7:0] got);
        if (exp_miso_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, {24'h0, got}, {24'h0, exp_miso_q.pop_front()});
        end
    endtask

    task automatic read_rx(input string tag);
        logic [7:0] d;
        bus_read(3'd0, d);
        if (exp_rx_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, {24'h0, d}, {24'h0, exp_rx_q.pop_front()});
        end
    endtask

    task automatic chk_status(input string tag, input logic [7:0] e);
        logic [7:0] d;
        bus_read(3'd1, d);
        check(tag, {24'h0, d}, {24'h0, e});
    endtask

    initial begin
        repeat (200000) @(negedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h1);
        check("rst_oe",   {31'h0, miso_oe}, 32'h0);
        check("rst_irq",  {31'h0, irq}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_status("t0_status", 8'h02);
        bus_write(3'd5, 8'h5A);
        bus_read(3'd5, v);
        check("t0_a5_reads0", {24'h0, v}, 32'h0);

        // 1: queued A5, master sends 3C
        bus_write(3'd0, 8'hA5);
        exp_miso_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        ss_low();
        check("t1_oe", {31'h0, miso_oe}, 32'h1);
        spi_bits(8'h3C, 8, r);
        pop_miso("t1_miso", r);
        // Trailing fall loaded the next byte with nothing queued -> underrun.
        chk_status("t1_status", 8'h1B);
        read_rx("t1_rx");
        chk_status("t1_status_rd", 8'h1A);
        ss_high();
        bus_write(3'd1, 8'h04);
        chk_status("t1_status_clr", 8'h02);

        // 2: nothing queued -> fill byte and underrun
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h5A);
        ss_low();
        spi_bits(8'h5A, 8, r);
        pop_miso("t2_miso", r);
        chk_status("t2_status_sel", 8'h1B);
        ss_high();
        chk_status("t2_status_idle", 8'h0B);
        bus_write(3'd1, 8'h04);
        chk_status("t2_status_clr", 8'h03);
        read_rx("t2_rx");
        chk_status("t2_status_rd", 8'h02);

        // 3: two bytes without a read -> overrun, irq
        exp_miso_q.push_back(8'hFF);
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h22);
        ss_low();
        spi_bits(8'h11, 8, r);
        pop_miso("t3_miso0", r);
        spi_bits(8'h22, 8, r);
        pop_miso("t3_miso1", r);
        ss_high();
        chk_status("t3_status", 8'h0F);
        bus_write(3'd2, 8'h04);
        check("t3_irq_on", {31'h0, irq}, 32'h1);
        read_rx("t3_rx");
        bus_write(3'd1, 8'h02);
        check("t3_irq_off", {31'h0, irq}, 32'h0);
        bus_write(3'd1, 8'h04);
        bus_write(3'd2, 8'h02);
        check("t3_irq_txempty", {31'h0, irq}, 32'h1);
        bus_read(3'd2, v);
        check("t3_mask", {24'h0, v}, 32'h02);
        bus_write(3'd2, 8'h00);
        check("t3_irq_mask0", {31'h0, irq}, 32'h0);

        // 4: back-to-back queued bytes in one frame
        bus_write(3'd0, 8'h81);
        exp_miso_q.push_back(8'h81);
        exp_miso_q.push_back(8'h7E);
        exp_rx_q.push_back(8'h96);
        exp_rx_q.push_back(8'h69);
        ss_low();
        fork
            spi_bits(8'h96, 8, r);
            begin
                repeat (20) @(negedge clk);
                bus_write(3'd0, 8'h7E);
            end
        join
        pop_miso("t4_miso0", r);
        chk_status("t4_status", 8'h13);
        read_rx("t4_rx0");
        spi_bits(8'h69, 8, r);
        pop_miso("t4_miso1", r);
        ss_high();
        read_rx("t4_rx1");
        chk_status("t4_status_end", 8'h0A);
        bus_write(3'd1, 8'h04);

        // 5: frame aborted after 5 bits
        ss_low();
        spi_bits(8'hF0, 5, r);
        ss_high();
        check("t5_miso", {31'h0, miso}, 32'h1);
        check("t5_oe", {31'h0, miso_oe}, 32'h0);
        chk_status("t5_status", 8'h0A);
        bus_write(3'd1, 8'h04);
        bus_write(3'd0, 8'h5A);
        exp_miso_q.push_back(8'h5A);
        exp_rx_q.push_back(8'hC3);
        ss_low();
        spi_bits(8'hC3, 8, r);
        pop_miso("t5_miso_next", r);
        ss_high();
        read_rx("t5_rx");
        bus_write(3'd1, 8'h04);

        // 6: reset with ss low mid-byte
        bus_write(3'd0, 8'h3C);
        bus_write(3'd2, 8'h02);
        check("t6_irq_queued", {31'h0, irq}, 32'h0);
        ss_low();
        check("t6_irq_loaded", {31'h0, irq}, 32'h1);
        spi_bits(8'hAA, 3, r);
        @(negedge clk);
        addr = 3'd1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_dout", {24'h0, dout}, 32'h0);
        check("t6_rst_miso", {31'h0, miso}, 32'h1);
        check("t6_rst_oe",   {31'h0, miso_oe}, 32'h0);
        check("t6_rst_irq",  {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_dout_status", {24'h0, dout}, 32'h02);
        spi_bits(8'hAA, 8, r);
        check("t6_oe_still0", {31'h0, miso_oe}, 32'h0);
        chk_status("t6_no_capture", 8'h02);
        ss_high();
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h55);
        ss_low();
        spi_bits(8'h55, 8, r);
        pop_miso("t6_miso", r);
        ss_high();
        read_rx("t6_rx");
        chk_status("t6_status_end", 8'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
